// File: rtl/outer_product_stream_pkg.sv
// Shared types and helpers for the outer-product row streamer.
package outer_product_pkg;

  typedef enum logic {IDLE, STREAM} op_state_e;

  function automatic int idx_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/outer_product_stream_if.sv
// Input vector and output row handshake bundle; slave is the streamer side.
interface outer_product_stream_if
  import outer_product_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN   = 8
) ();
  localparam int IDX_W = idx_w(LEN);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a [LEN];
  logic [WIDTH-1:0] b [LEN];
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] row [LEN];
  logic [IDX_W-1:0] row_idx;
  logic             row_last;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, row, row_idx, row_last
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, row, row_idx, row_last
  );
endinterface

// File: rtl/outer_product_stream_mul.sv
// Unsigned WIDTH x WIDTH multiplier keeping the low WIDTH bits of the product.
module multiplier #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] p
);
  assign p = x * y;
endmodule

// File: rtl/outer_product_stream.sv
// Emits LEN rows per accepted (a, b) pair; row i is a[i] times each b[j].
module outer_product_stream
  import outer_product_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN   = 8
) (
  input logic clk,
  input logic rst,
  outer_product_stream_if.slave bus
);
  localparam int IDX_W = idx_w(LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);

  op_state_e        state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             load;
  logic [WIDTH-1:0] a_q [LEN];
  logic [WIDTH-1:0] b_q [LEN];
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] row_w [LEN];

  assign bus.out_valid = (state == STREAM);
  assign bus.row_last  = (state == STREAM) && (idx == LAST);
  assign bus.row_idx   = idx;
  // Accepting on the last beat lets a new pair follow with no bubble.
  assign bus.in_ready  = !rst && ((state == IDLE) ||
                                  ((state == STREAM) && (idx == LAST) && bus.out_ready));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load      = 1'b1;
          idx_nxt   = '0;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (idx == LAST) begin
            idx_nxt = '0;
            if (bus.in_valid) load = 1'b1;
            else              state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      for (int j = 0; j < LEN; j++) begin
        a_q[j] <= '0;
        b_q[j] <= '0;
      end
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (load) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
    end
  end

  // One shared row-multiplier select feeds every column multiplier.
  assign a_sel = a_q[idx];

  for (genvar j = 0; j < LEN; j++) begin : g_mul
    multiplier #(.WIDTH(WIDTH)) u_mul (
      .x (a_sel),
      .y (b_q[j]),
      .p (row_w[j])
    );
  end

  assign bus.row = row_w;
endmodule

// File: tb/tb_outer_product_stream.sv
// Directed checks of reset, streaming, stalls, back-to-back, truncation and mid-stream reset.
module tb_outer_product_stream;
  localparam int WIDTH = 32;
  localparam int LEN   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  outer_product_stream_if #(.WIDTH(WIDTH), .LEN(LEN)) bus ();

  outer_product_stream #(.WIDTH(WIDTH), .LEN(LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_basic();
    for (int j = 0; j < LEN; j++) begin
      bus.a[j] = 32'(j + 1);
      bus.b[j] = 32'((j + 1) * 10);
    end
  endtask

  task automatic load_basic();
    set_basic();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int j = 0; j < LEN; j++) begin
      bus.a[j] = '0;
      bus.b[j] = '0;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.row_idx !== '0) begin
        fails++;
        $display("FAIL reset_ctrl cyc%0d got ov=%b ir=%b idx=%0d exp ov=0 ir=0 idx=0",
                 c, bus.out_valid, bus.in_ready, bus.row_idx);
      end
      for (int j = 0; j < LEN; j++) begin
        tests++;
        if (bus.row[j] !== '0) begin
          fails++;
          $display("FAIL reset_row[%0d] got %0h exp 0", j, bus.row[j]);
        end
      end
    end
    rst = 1'b0;
    tick();
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got ir=%b ov=%b exp ir=1 ov=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    load_basic();
    for (int i = 0; i < LEN; i++) begin
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.row_idx !== 3'(i) || bus.row_last !== (i == LEN - 1)) begin
        fails++;
        $display("FAIL basic_ctrl row%0d got ov=%b idx=%0d last=%b exp ov=1 idx=%0d last=%b",
                 i, bus.out_valid, bus.row_idx, bus.row_last, i, (i == LEN - 1));
      end
      for (int j = 0; j < LEN; j++) begin
        tests++;
        if (bus.row[j] !== 32'((i + 1) * (j + 1) * 10)) begin
          fails++;
          $display("FAIL basic_row%0d[%0d] got %0d exp %0d", i, j, bus.row[j], (i + 1) * (j + 1) * 10);
        end
      end
      tick();
    end
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_after got ov=%b ir=%b exp ov=0 ir=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    int exp_idx;
    logic rdy;
    exp_idx = 0;
    bus.out_ready = 1'b1;
    load_basic();
    for (int c = 0; c < 40 && exp_idx < LEN; c++) begin
      rdy = ((c % 4) == 0) || ((c % 4) == 3);
      bus.out_ready = rdy;
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.row_idx !== 3'(exp_idx) ||
          bus.row_last !== (exp_idx == LEN - 1)) begin
        fails++;
        $display("FAIL bp_ctrl cyc%0d got ov=%b idx=%0d last=%b exp ov=1 idx=%0d last=%b",
                 c, bus.out_valid, bus.row_idx, bus.row_last, exp_idx, (exp_idx == LEN - 1));
      end
      for (int j = 0; j < LEN; j++) begin
        tests++;
        if (bus.row[j] !== 32'((exp_idx + 1) * (j + 1) * 10)) begin
          fails++;
          $display("FAIL bp_row%0d[%0d] got %0d exp %0d", exp_idx, j, bus.row[j],
                   (exp_idx + 1) * (j + 1) * 10);
        end
      end
      tick();
      if (rdy) exp_idx++;
    end
    tests++;
    if (exp_idx != LEN) begin
      fails++;
      $display("FAIL bp_timeout got %0d rows exp %0d", exp_idx, LEN);
    end
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_after got ov=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    load_basic();
    for (int j = 0; j < LEN; j++) begin
      bus.a[j] = 32'd2;
      bus.b[j] = 32'd3;
    end
    bus.in_valid = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      #1;
      tests++;
      if (bus.row_idx !== 3'(i) || bus.in_ready !== (i == LEN - 1) ||
          bus.row[LEN-1] !== 32'((i + 1) * LEN * 10)) begin
        fails++;
        $display("FAIL b2b_first row%0d got idx=%0d ir=%b r7=%0d exp idx=%0d ir=%b r7=%0d",
                 i, bus.row_idx, bus.in_ready, bus.row[LEN-1], i, (i == LEN - 1), (i + 1) * LEN * 10);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.row_idx !== 3'(i)) begin
        fails++;
        $display("FAIL b2b_second_ctrl row%0d got ov=%b idx=%0d exp ov=1 idx=%0d",
                 i, bus.out_valid, bus.row_idx, i);
      end
      for (int j = 0; j < LEN; j++) begin
        tests++;
        if (bus.row[j] !== 32'd6) begin
          fails++;
          $display("FAIL b2b_second_row%0d[%0d] got %0d exp 6", i, j, bus.row[j]);
        end
      end
      tick();
    end
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_after got ov=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_truncation();
    bus.out_ready = 1'b1;
    for (int j = 0; j < LEN; j++) begin
      bus.a[j] = '0;
      bus.b[j] = '0;
    end
    bus.a[0] = 32'hFFFF_FFFF;
    bus.b[0] = 32'd2;
    bus.b[1] = 32'h8000_0001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    tests++;
    if (bus.row[0] !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL trunc_r0e0 got %08h exp fffffffe", bus.row[0]);
    end
    tests++;
    if (bus.row[1] !== 32'h7FFF_FFFF) begin
      fails++;
      $display("FAIL trunc_r0e1 got %08h exp 7fffffff", bus.row[1]);
    end
    for (int i = 0; i < LEN; i++) tick();
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL trunc_after got ov=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_midreset();
    bus.out_ready = 1'b1;
    load_basic();
    tick();
    tick();
    tick();
    #1;
    tests++;
    if (bus.row_idx !== 3'd3 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre got idx=%0d ov=%b exp idx=3 ov=1", bus.row_idx, bus.out_valid);
    end
    rst = 1'b1;
    tick();
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.row_idx !== '0) begin
      fails++;
      $display("FAIL midrst_hit got ov=%b ir=%b idx=%0d exp ov=0 ir=0 idx=0",
               bus.out_valid, bus.in_ready, bus.row_idx);
    end
    rst = 1'b0;
    for (int c = 0; c < LEN; c++) begin
      tick();
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL midrst_drop cyc%0d got ov=%b ir=%b exp ov=0 ir=1", c, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_truncation();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
